restador_serie: RTL
===================

Name: restador_serie

Overview:
- Bit-serial WIDTH-bit ripple-borrow subtractor: computes d = a - b - bi, one bit per clock, LSB first, through a registered borrow chain.
- It is the subtracting counterpart of the team's combinational ripple-carry adder, sharing the same one-bit-cell style of datapath.
- Sits in the power-analysis test designs as a sequential, low-area alternative, so switching activity per cycle can be compared against the parallel adder.

Parameters:
WIDTH, 8, operand and result width in bits (min 2).
PwrC, 0, power-characterisation tag passed to gate cells; no functional effect.

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bi  input  1  borrow-in; captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when d/bo are valid
d  output  WIDTH  difference
bo  output  1  borrow-out (1 = a < b + bi, unsigned)

Behaviour:
Reset:
- Asynchronous, active-low, on reset_L.
- Sets state=IDLE and clears busy, done, d, bo, count, the borrow register and the operand shift registers.
- Asserting reset mid-operation aborts the operation; no done is produced.

FSM states:
- IDLE: start=1 captures a, b and bi (into the borrow register), sets count=0, goes to SHIFT.
- SHIFT: each cycle processes bit i=count:
  - d[i] = a[i] ^ b[i] ^ br
  - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
  - Result bits are shifted into d from the MSB side, so after WIDTH cycles d holds the full result in order.
  - count increments; when count==WIDTH-1, goes to DONE.
- DONE: bo = final borrow, done=1 for exactly this cycle, then returns to IDLE.

Timing:
- Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH+1 (9 edges for WIDTH=8).
- Minimum start-to-start spacing is WIDTH+2 cycles.

Outputs and start handling:
- d and bo hold their last result until the next accepted start. On acceptance d clears to 0 and updates bit-by-bit during SHIFT.
- Only the values at the DONE pulse are architecturally valid.
- start while busy or in DONE is ignored: no re-capture, no queueing.
- start held high continuously re-triggers on each return to IDLE.

Arithmetic:
- Unsigned modulo 2^WIDTH. a, b and bi are not re-read after capture, so input changes during SHIFT have no effect.

Optional Feature:
Macro RESTADOR_SERIE_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit): two's-complement signed overflow = (borrow into MSB) XOR bo.
  - Valid with done and held like d; reset value 0.
- Undefined: no ovf port and no extra register; all other behaviour identical.

Decomposition:
- Shared package restador_pkg holds:
  - the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10)
  - the default WIDTH constant
  - the count width, clog2(WIDTH)
- One sub-module, restador_completo: combinational 1-bit full subtractor (a, b, bi -> d, bo) built from xor2_p/and2_p/or3_p cells with PwrC passed down. The top instantiates it once and feeds it from the shift registers.

Test Plan:
- a=8'h05, b=8'h03, bi=0, start pulse at cycle 0 -> busy for cycles 1-8, done at cycle 9, d=8'h02, bo=0.
- a=8'h00, b=8'h01, bi=0 -> d=8'hFF, bo=1; a=8'h10, b=8'h0F, bi=1 -> d=8'h00, bo=0.
- Start accepted with a=8'h20, b=8'h01; pulse start with a=8'hFF at cycles 3 and 9 -> both ignored; done at cycle 9 with d=8'h1F; next done only after a new start in IDLE.
- Drop reset_L at cycle 4 of an operation -> outputs 0 immediately; no done; a start after release gives a correct result (8'hAA-8'h55 -> 8'h55, bo=0).
- Back-to-back: start held high for 30 cycles with constant operands -> done every WIDTH+2 cycles with an identical result each time.
- RESTADOR_SERIE_OVF_EN: 8'h80-8'h01 -> d=8'h7F, ovf=1, bo=0; 8'h05-8'h03 -> ovf=0. Macro undefined: the design elaborates without an ovf port.

Source files
------------

// File: rtl/restador_pkg.sv
// rtl/restador_pkg.sv - shared state encoding and sizing helpers for restador_serie
package restador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-index counter width; a 1-bit floor keeps WIDTH=2 legal.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/restador_completo.sv
// rtl/restador_completo.sv - 1-bit full subtractor cell built from tagged gate primitives
module xor2_p #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    output logic y
);
    if (PwrC < 0) begin : g_tag
    end
    assign y = a ^ b;
endmodule

module and2_p #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    output logic y
);
    if (PwrC < 0) begin : g_tag
    end
    assign y = a & b;
endmodule

module or3_p #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    if (PwrC < 0) begin : g_tag
    end
    assign y = a | b | c;
endmodule

module restador_completo #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic x_ab;
    logic t_nab, t_nabi, t_bbi;

    xor2_p #(.PwrC(PwrC)) u_x0 (.a(a),    .b(b),  .y(x_ab));
    xor2_p #(.PwrC(PwrC)) u_x1 (.a(x_ab), .b(bi), .y(d));

    // Borrow as sum of products: ~a&b | ~a&bi | b&bi
    and2_p #(.PwrC(PwrC)) u_a0 (.a(~a), .b(b),  .y(t_nab));
    and2_p #(.PwrC(PwrC)) u_a1 (.a(~a), .b(bi), .y(t_nabi));
    and2_p #(.PwrC(PwrC)) u_a2 (.a(b),  .b(bi), .y(t_bbi));
    or3_p  #(.PwrC(PwrC)) u_o0 (.a(t_nab), .b(t_nabi), .c(t_bbi), .y(bo));
endmodule

// File: rtl/restador_serie.sv
// rtl/restador_serie.sv - bit-serial ripple-borrow subtractor; RESTADOR_SERIE_OVF_EN adds ovf
module restador_serie
    import restador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PwrC  = 0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef RESTADOR_SERIE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic [CW-1:0]    count_q;
    logic             br_q, busy_q, done_q, bo_q;
    logic             dbit_d, br_d;

    // Single cell always looks at bit 0; operands shift right under it.
    restador_completo #(.PwrC(PwrC)) u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (br_q),
        .d  (dbit_d),
        .bo (br_d)
    );

`ifdef RESTADOR_SERIE_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bo_q    <= 1'b0;
`ifdef RESTADOR_SERIE_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bi;
                        d_q     <= '0;
                        bo_q    <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef RESTADOR_SERIE_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    d_q     <= {dbit_d, d_q[WIDTH-1:1]};
                    br_q    <= br_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bo_q    <= br_d;
                        state_q <= DONE;
`ifdef RESTADOR_SERIE_OVF_EN
                        // br_q here is the borrow into the MSB
                        ovf_q   <= br_q ^ br_d;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bo   = bo_q;

endmodule
